// File: rtl/pico_pkg.sv
// Shared types and constants for the picoMIPS control unit: datapath sizes,
// instruction field positions, opcode/ALU/state enums and opcode classing.
package pico_pkg;

  localparam int N     = 8;   // datapath width
  localparam int PSIZE = 6;   // program counter width
  localparam int ISIZE = 18;  // instruction width

  // Instruction word layout: op[17:14] rd[13:11] rs[10:8] imm[7:0]
  localparam int OP_HI  = 17;
  localparam int OP_LO  = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int RS_HI  = 10;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_ADDI  = 4'd3,
    OP_MUL   = 4'd4,
    OP_MULI  = 4'd5,
    OP_IN    = 4'd6,
    OP_OUT   = 4'd7,
    OP_BNZ   = 4'd8,
    OP_JMP   = 4'd9,
    OP_WAITR = 4'd10
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_PASSB = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_ADD   = 2'b10,
    ALU_MUL   = 2'b11
  } alu_func_e;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_EXEC     = 3'd1,
    S_WAIT_IN  = 3'd2,
    S_WAIT_REL = 3'd3,
    S_WB       = 3'd4
  } state_e;

  // Coarse behaviour class; everything the FSM and strobe logic need to know.
  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_IN    = 3'd2,
    CLS_OUT   = 3'd3,
    CLS_BNZ   = 3'd4,
    CLS_JMP   = 3'd5,
    CLS_WAITR = 3'd6
  } op_class_e;

  // Undefined opcodes (11..15) fall into the NOP class.
  function automatic op_class_e op_class(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI,
      OP_MUL, OP_MULI: op_class = CLS_ALU;
      OP_IN:           op_class = CLS_IN;
      OP_OUT:          op_class = CLS_OUT;
      OP_BNZ:          op_class = CLS_BNZ;
      OP_JMP:          op_class = CLS_JMP;
      OP_WAITR:        op_class = CLS_WAITR;
      default:         op_class = CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/pico_ctrl_if.sv
// Bus between the control unit and the rest of the picoMIPS datapath
// (program memory, ALU, register file, PC and the switch input port).
interface pico_ctrl_if;
  import pico_pkg::*;

  logic [ISIZE-1:0] instr;
  logic [N-1:0]     alu_result;
  logic             in_valid;
  logic             in_ack;
  logic [1:0]       ALUFunc;
  logic [2:0]       rd_addr;
  logic [2:0]       rs_addr;
  logic [N-1:0]     imm;
  logic             b_sel;
  logic             wd_sel;
  logic             reg_we;
  logic             out_load;
  logic             pc_inc;
  logic             pc_load;
  logic [PSIZE-1:0] pc_target;
  logic             z_flag;

  // Control unit side
  modport master (
    input  instr, alu_result, in_valid,
    output in_ack, ALUFunc, rd_addr, rs_addr, imm, b_sel, wd_sel,
           reg_we, out_load, pc_inc, pc_load, pc_target, z_flag
  );

  // Datapath side
  modport slave (
    output instr, alu_result, in_valid,
    input  in_ack, ALUFunc, rd_addr, rs_addr, imm, b_sel, wd_sel,
           reg_we, out_load, pc_inc, pc_load, pc_target, z_flag
  );

endinterface

// File: rtl/pico_idecode.sv
// Combinational instruction decoder: splits IR into fields and derives the
// ALU function, operand/write-data selects and the instruction class.
module pico_idecode
  import pico_pkg::*;
(
  input  logic [ISIZE-1:0] i_ir,
  output op_class_e        o_cls,
  output logic [1:0]       o_alu_func,
  output logic             o_b_sel,
  output logic             o_wd_sel,
  output logic [2:0]       o_rd,
  output logic [2:0]       o_rs,
  output logic [N-1:0]     o_imm
);

  logic [3:0] w_op;

  assign w_op  = i_ir[OP_HI:OP_LO];
  assign o_rd  = i_ir[RD_HI:RD_LO];
  assign o_rs  = i_ir[RS_HI:RS_LO];
  assign o_imm = i_ir[IMM_HI:IMM_LO];
  assign o_cls = op_class(w_op);

  // ALU function and selects per opcode; non-ALU ops leave the ALU in pass-B
  always_comb begin
    o_alu_func = ALU_PASSB;
    o_b_sel    = 1'b0;
    o_wd_sel   = 1'b0;
    case (w_op)
      OP_ADD:  o_alu_func = ALU_ADD;
      OP_SUB:  o_alu_func = ALU_SUB;
      OP_ADDI: begin
        o_alu_func = ALU_ADD;
        o_b_sel    = 1'b1;
      end
      OP_MUL:  o_alu_func = ALU_MUL;
      OP_MULI: begin
        o_alu_func = ALU_MUL;
        o_b_sel    = 1'b1;
      end
      OP_IN:   o_wd_sel = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pico_ctrl.sv
// picoMIPS multicycle control unit. Holds the instruction register, the
// FETCH/EXEC/WAIT/WB sequencer, the zero flag and the one-cycle WB strobes.
module pico_ctrl
  import pico_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  pico_ctrl_if.master bus
);

  state_e           r_state;
  logic [ISIZE-1:0] r_ir;
  logic             r_z;
  logic             r_reg_we;
  logic             r_in_ack;
  logic             r_out_load;
  logic             r_pc_inc;
  logic             r_pc_load;

  op_class_e        w_cls;
  op_class_e        w_fetch_cls;
  logic [1:0]       w_alu_func;
  logic             w_b_sel;
  logic             w_wd_sel;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs;
  logic [N-1:0]     w_imm;

  logic             w_reg_we;
  logic             w_in_ack;
  logic             w_out_load;
  logic             w_pc_inc;
  logic             w_pc_load;

  pico_idecode u_idecode (
    .i_ir       (r_ir),
    .o_cls      (w_cls),
    .o_alu_func (w_alu_func),
    .o_b_sel    (w_b_sel),
    .o_wd_sel   (w_wd_sel),
    .o_rd       (w_rd),
    .o_rs       (w_rs),
    .o_imm      (w_imm)
  );

  // Class of the word on the instruction bus, used to pick the FETCH successor
  assign w_fetch_cls = op_class(bus.instr[OP_HI:OP_LO]);

  // Strobe pattern to register on entry to WB; BNZ sees z_flag as it stands now,
  // which already includes an ALU op retired just before it
  always_comb begin
    w_reg_we   = (w_cls == CLS_ALU) || (w_cls == CLS_IN);
    w_in_ack   = (w_cls == CLS_IN);
    w_out_load = (w_cls == CLS_OUT);
    w_pc_load  = (w_cls == CLS_JMP) || ((w_cls == CLS_BNZ) && !r_z);
    w_pc_inc   = !w_pc_load;
  end

  // Sequencer, IR, zero flag and registered WB strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_ir       <= '0;
      r_z        <= 1'b0;
      r_reg_we   <= 1'b0;
      r_in_ack   <= 1'b0;
      r_out_load <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_pc_load  <= 1'b0;
    end else begin
      r_reg_we   <= 1'b0;
      r_in_ack   <= 1'b0;
      r_out_load <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_pc_load  <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ir <= bus.instr;
          case (w_fetch_cls)
            CLS_IN:    r_state <= S_WAIT_IN;
            CLS_WAITR: r_state <= S_WAIT_REL;
            default:   r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          r_state    <= S_WB;
          r_reg_we   <= w_reg_we;
          r_in_ack   <= w_in_ack;
          r_out_load <= w_out_load;
          r_pc_inc   <= w_pc_inc;
          r_pc_load  <= w_pc_load;
        end
        S_WAIT_IN: begin
          if (bus.in_valid) begin
            r_state    <= S_WB;
            r_reg_we   <= w_reg_we;
            r_in_ack   <= w_in_ack;
            r_out_load <= w_out_load;
            r_pc_inc   <= w_pc_inc;
            r_pc_load  <= w_pc_load;
          end
        end
        S_WAIT_REL: begin
          if (!bus.in_valid) begin
            r_state    <= S_WB;
            r_reg_we   <= w_reg_we;
            r_in_ack   <= w_in_ack;
            r_out_load <= w_out_load;
            r_pc_inc   <= w_pc_inc;
            r_pc_load  <= w_pc_load;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          if (w_cls == CLS_ALU)
            r_z <= (bus.alu_result == '0);
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign bus.ALUFunc   = w_alu_func;
  assign bus.rd_addr   = w_rd;
  assign bus.rs_addr   = w_rs;
  assign bus.imm       = w_imm;
  assign bus.b_sel     = w_b_sel;
  assign bus.wd_sel    = w_wd_sel;
  assign bus.reg_we    = r_reg_we;
  assign bus.in_ack    = r_in_ack;
  assign bus.out_load  = r_out_load;
  assign bus.pc_inc    = r_pc_inc;
  assign bus.pc_load   = r_pc_load;
  assign bus.pc_target = w_imm[PSIZE-1:0];
  assign bus.z_flag    = r_z;

endmodule

// File: tb/tb_pico_ctrl.sv
// Directed bench for pico_ctrl: steps instructions through the sequencer and
// checks decoded outputs, WB strobes and the zero flag cycle by cycle.
module tb_pico_ctrl;
  import pico_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  pico_ctrl_if bus ();

  pico_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe tuple order: {reg_we, in_ack, out_load, pc_inc, pc_load}
  localparam logic [4:0] ST_NONE = 5'b00000;
  localparam logic [4:0] ST_ALU  = 5'b10010;
  localparam logic [4:0] ST_IN   = 5'b11010;
  localparam logic [4:0] ST_OUT  = 5'b00110;
  localparam logic [4:0] ST_INC  = 5'b00010;
  localparam logic [4:0] ST_LOAD = 5'b00001;

  function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [7:0] imm);
    mk = {op, rd, rs, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, bus.reg_we, bus.in_ack, bus.out_load, bus.pc_inc, bus.pc_load},
        {27'd0, exp});
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.instr     = '0;
    bus.alu_result = '0;
    bus.in_valid  = 1'b0;
    tick();
    tick();
    chk_st("reset_strobes", ST_NONE);
    chk("reset_alufunc", {30'd0, bus.ALUFunc}, 32'd0);
    chk("reset_z", {31'd0, bus.z_flag}, 32'd0);
    reset = 1'b0;

    // ADDI r1, 0x14 ; result 0x17 -> z = 0
    bus.instr = mk(4'd3, 3'd1, 3'd0, 8'h14);
    tick();
    chk("addi_alufunc", {30'd0, bus.ALUFunc}, 32'd2);
    chk("addi_bsel", {31'd0, bus.b_sel}, 32'd1);
    chk("addi_rd", {29'd0, bus.rd_addr}, 32'd1);
    chk("addi_imm", {24'd0, bus.imm}, 32'h14);
    chk_st("addi_exec_st", ST_NONE);
    tick();
    chk_st("addi_wb_st", ST_ALU);
    chk("addi_wdsel", {31'd0, bus.wd_sel}, 32'd0);
    bus.alu_result = 8'h17;
    tick();
    chk_st("addi_fetch_st", ST_NONE);
    chk("addi_z", {31'd0, bus.z_flag}, 32'd0);

    // MULI r2, 0x60 ; result 0x00 -> z = 1
    bus.instr = mk(4'd5, 3'd2, 3'd0, 8'h60);
    tick();
    chk("muli_alufunc", {30'd0, bus.ALUFunc}, 32'd3);
    chk("muli_bsel", {31'd0, bus.b_sel}, 32'd1);
    tick();
    chk_st("muli_wb_st", ST_ALU);
    bus.alu_result = 8'h00;
    tick();
    chk("muli_z", {31'd0, bus.z_flag}, 32'd1);

    // BNZ 0x05 with z = 1 -> fall through
    bus.instr = mk(4'd8, 3'd0, 3'd0, 8'h05);
    bus.alu_result = 8'h55;
    tick();
    chk_st("bnz_taken_exec_st", ST_NONE);
    tick();
    chk_st("bnz_z1_wb_st", ST_INC);
    chk("bnz_z1_target", {26'd0, bus.pc_target}, 32'h05);
    tick();
    chk("bnz_z_kept", {31'd0, bus.z_flag}, 32'd1);

    // SUB r3, r4 ; result 0x22 -> z = 0
    bus.instr = mk(4'd2, 3'd3, 3'd4, 8'h00);
    tick();
    chk("sub_alufunc", {30'd0, bus.ALUFunc}, 32'd1);
    chk("sub_bsel", {31'd0, bus.b_sel}, 32'd0);
    chk("sub_rs", {29'd0, bus.rs_addr}, 32'd4);
    tick();
    bus.alu_result = 8'h22;
    tick();
    chk("sub_z", {31'd0, bus.z_flag}, 32'd0);

    // BNZ 0x0A with z = 0 -> branch
    bus.instr = mk(4'd8, 3'd0, 3'd0, 8'h0A);
    tick();
    tick();
    chk_st("bnz_z0_wb_st", ST_LOAD);
    chk("bnz_z0_target", {26'd0, bus.pc_target}, 32'h0A);
    tick();

    // OUT r5
    bus.instr = mk(4'd7, 3'd5, 3'd0, 8'h00);
    tick();
    tick();
    chk_st("out_wb_st", ST_OUT);
    tick();
    chk_st("out_fetch_st", ST_NONE);

    // JMP 0x3F
    bus.instr = mk(4'd9, 3'd0, 3'd0, 8'hFF);
    tick();
    tick();
    chk_st("jmp_wb_st", ST_LOAD);
    chk("jmp_target", {26'd0, bus.pc_target}, 32'h3F);
    tick();

    // IN r6 with in_valid low for 4 cycles
    bus.instr = mk(4'd6, 3'd6, 3'd0, 8'h00);
    tick();
    chk("in_wdsel", {31'd0, bus.wd_sel}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_st("in_wait_st", ST_NONE);
    end
    bus.in_valid = 1'b1;
    tick();
    chk_st("in_wb_st", ST_IN);
    chk("in_wb_wdsel", {31'd0, bus.wd_sel}, 32'd1);
    tick();
    chk_st("in_after_st", ST_NONE);
    chk("in_z_unchanged", {31'd0, bus.z_flag}, 32'd0);

    // WAITR holds while in_valid = 1
    bus.instr = mk(4'd10, 3'd0, 3'd0, 8'h00);
    tick();
    tick();
    chk_st("waitr_hold1_st", ST_NONE);
    tick();
    chk_st("waitr_hold2_st", ST_NONE);
    bus.in_valid = 1'b0;
    tick();
    chk_st("waitr_wb_st", ST_INC);
    tick();
    chk_st("waitr_done_st", ST_NONE);

    // IN with in_valid already high: 3 cycles
    bus.in_valid = 1'b1;
    bus.instr = mk(4'd6, 3'd1, 3'd0, 8'h00);
    tick();
    chk_st("in_fast_wait_st", ST_NONE);
    tick();
    chk_st("in_fast_wb_st", ST_IN);
    tick();
    bus.in_valid = 1'b0;

    // Opcode 13 behaves as NOP
    bus.instr = mk(4'd13, 3'd7, 3'd7, 8'hFF);
    tick();
    chk("op13_alufunc", {30'd0, bus.ALUFunc}, 32'd0);
    chk_st("op13_exec_st", ST_NONE);
    tick();
    chk_st("op13_wb_st", ST_INC);
    tick();
    chk_st("op13_fetch_st", ST_NONE);

    // Set z = 1 via ADD, then reset in the middle of WAIT_IN
    bus.instr = mk(4'd1, 3'd1, 3'd2, 8'h00);
    tick();
    tick();
    bus.alu_result = 8'h00;
    tick();
    chk("add_z", {31'd0, bus.z_flag}, 32'd1);
    bus.instr = mk(4'd6, 3'd2, 3'd0, 8'h00);
    tick();
    tick();
    chk_st("in_pre_reset_st", ST_NONE);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_z", {31'd0, bus.z_flag}, 32'd0);
    chk_st("rst_async_st", ST_NONE);
    bus.in_valid = 1'b1;
    tick();
    chk_st("rst_held_st", ST_NONE);
    chk("rst_held_ack", {31'd0, bus.in_ack}, 32'd0);
    reset = 1'b0;
    tick();
    chk_st("rst_restart_fetch_st", ST_NONE);
    tick();
    chk_st("rst_restart_wb_st", ST_IN);
    tick();
    bus.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
